// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit multiplexed seven-segment display between two requesters.
// Ownership changes on frame boundaries; define DISP_BLINK_EN to add owner-driven blinking.
module seg_display_arbiter #(
    parameter int SCAN_DIV        = 25000,
    parameter int MIN_HOLD_FRAMES = 4,
    parameter int BLINK_FRAMES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [19:0] data_a,
    input  logic [3:0]  mask_a,
    input  logic        blink_a,
    input  logic        req_b,
    input  logic [19:0] data_b,
    input  logic [3:0]  mask_b,
    input  logic        blink_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  an,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp,
    output logic        frame_done
);
    // req_x is a level held for as long as the requester wants the display;
    // gnt_x is registered, at most one is high, and it only moves on a frame boundary.

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = $clog2(MIN_HOLD_FRAMES + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST    = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX     = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_PREEMPT = HOLD_W'(MIN_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [1:0]         digit_q, digit_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [19:0]        snap_data_q, snap_data_d;
    logic [3:0]         snap_mask_q, snap_mask_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               tick;
    logic               boundary;
    logic               hold_met;
    logic               gnt_change;
    logic               blank;
    logic [4:0]         glyph;

    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b0000001;
            5'd1:    s = 7'b1001111;
            5'd2:    s = 7'b0010010;
            5'd3:    s = 7'b0000110;
            5'd4:    s = 7'b1001100;
            5'd5:    s = 7'b0100100;
            5'd6:    s = 7'b0100000;
            5'd7:    s = 7'b0001111;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0000100;
            5'd10:   s = 7'b0001000;
            5'd11:   s = 7'b1100000;
            5'd12:   s = 7'b0110001;
            5'd13:   s = 7'b1000010;
            5'd14:   s = 7'b0110000;
            5'd15:   s = 7'b0111000;
            5'd16:   s = 7'b0011000;
            5'd17:   s = 7'b1110001;
            5'd18:   s = 7'b1111110;
            5'd19:   s = 7'b1001000;
            5'd20:   s = 7'b1111001;
            5'd21:   s = 7'b1100000;
            5'd22:   s = 7'b0000001;
            5'd23:   s = 7'b0001000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // A has held long enough once the frame now ending brings it to MIN_HOLD_FRAMES.
    always_comb begin
        tick     = (scan_q == SCAN_LAST);
        boundary = tick && (digit_q == 2'd3);
        hold_met = (hold_q >= HOLD_PREEMPT);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_b) begin
                    state_d = OWN_B;
                end else if (req_a) begin
                    state_d = OWN_A;
                end
            end
            OWN_A: begin
                if (boundary) begin
                    if (req_b && hold_met) begin
                        state_d = OWN_B;
                    end else if (!req_a) begin
                        state_d = req_b ? OWN_B : IDLE;
                    end
                end
            end
            OWN_B: begin
                if (boundary && !req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_change = (state_d != state_q);
    end

    always_comb begin
        scan_d  = scan_q;
        digit_d = digit_q;
        hold_d  = hold_q;
        if (gnt_change || (state_q == IDLE)) begin
            scan_d  = '0;
            digit_d = 2'd0;
            hold_d  = '0;
        end else begin
            if (tick) begin
                scan_d  = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                scan_d = scan_q + 1'b1;
            end
            if (boundary && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // The snapshot only moves between frames so a frame never tears mid-scan.
    always_comb begin
        snap_data_d = snap_data_q;
        snap_mask_d = snap_mask_q;
        if (gnt_change || boundary) begin
            if (state_d == OWN_A) begin
                snap_data_d = data_a;
                snap_mask_d = mask_a;
            end else if (state_d == OWN_B) begin
                snap_data_d = data_b;
                snap_mask_d = mask_b;
            end
        end
    end

    always_comb begin
        case (digit_q)
            2'd0:    glyph = snap_data_q[4:0];
            2'd1:    glyph = snap_data_q[9:5];
            2'd2:    glyph = snap_data_q[14:10];
            default: glyph = snap_data_q[19:15];
        endcase

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if ((state_q != IDLE) && snap_mask_q[digit_q] && !blank) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = decode_glyph(glyph);
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               owner_blink;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (gnt_change) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (boundary) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        owner_blink = ((state_q == OWN_A) && blink_a) || ((state_q == OWN_B) && blink_b);
        blank       = blink_phase_q && owner_blink;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{blink_a, blink_b, (BLINK_FRAMES > 0)};
    assign blank        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            digit_q     <= 2'd0;
            hold_q      <= '0;
            snap_data_q <= '0;
            snap_mask_q <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            hold_q      <= hold_d;
            snap_data_q <= snap_data_d;
            snap_mask_q <= snap_mask_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign gnt_a      = (state_q == OWN_A);
    assign gnt_b      = (state_q == OWN_B);
    assign an         = an_q;
    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp         = 1'b1;
    assign frame_done = boundary && (state_q != IDLE);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: expected {frame_done, an, segments} per cycle
// are queued when stimulus is applied and compared as the display scans.
module tb_seg_display_arbiter;
    localparam int SCAN_DIV        = 4;
    localparam int MIN_HOLD_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0;
    logic [19:0] data_a = '0;
    logic [3:0]  mask_a = '0;
    logic        blink_a = 1'b0;
    logic        req_b = 1'b0;
    logic [19:0] data_b = '0;
    logic [3:0]  mask_b = '0;
    logic        blink_b = 1'b0;
    logic        gnt_a, gnt_b;
    logic [3:0]  an;
    logic        a, b, c, d, e, f, g, dp;
    logic        frame_done;
    logic [6:0]  seg;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] exp_q[$];
    logic [6:0]  seg_tbl[32];

    assign seg = {a, b, c, d, e, f, g};

    seg_display_arbiter #(
        .SCAN_DIV(SCAN_DIV),
        .MIN_HOLD_FRAMES(MIN_HOLD_FRAMES),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .mask_a(mask_a), .blink_a(blink_a),
        .req_b(req_b), .data_b(data_b), .mask_b(mask_b), .blink_b(blink_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .an(an),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame as seen on the registered outputs, starting the cycle after the frame's first edge.
    task automatic push_frame(input logic [19:0] data, input logic [3:0] mask);
        int         dg;
        logic [4:0] gl;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        for (int j = 1; j <= 16; j++) begin
            dg = (j - 1) / 4;
            gl = data[dg*5 +: 5];
            if (mask[dg]) begin
                an_e  = ~(4'b0001 << dg);
                seg_e = seg_tbl[gl];
            end else begin
                an_e  = 4'b1111;
                seg_e = 7'b1111111;
            end
            exp_q.push_back({(j == 15), an_e, seg_e});
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 4'b1111, 7'b1111111});
    endtask

    task automatic pop_check(input string tag);
        logic [11:0] ev;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s observed=output required=queued_expectation", tag);
        end else begin
            ev = exp_q.pop_front();
            check(tag, {frame_done, an, seg}, ev);
        end
    endtask

    initial begin
        seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
        seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
        seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
        seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
        seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
        seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;
        seg_tbl[16] = 7'b0011000; seg_tbl[17] = 7'b1110001;
        seg_tbl[18] = 7'b1111110; seg_tbl[19] = 7'b1001000;
        seg_tbl[20] = 7'b1111001; seg_tbl[21] = 7'b1100000;
        seg_tbl[22] = 7'b0000001; seg_tbl[23] = 7'b0001000;
        for (int i = 24; i < 32; i++) seg_tbl[i] = 7'b1111111;

        // Reset held for three cycles, then idle with no requests.
        repeat (3) cyc();
        check("rst_out", {gnt_a, gnt_b, frame_done, an, seg}, {2'b00, 1'b0, 4'b1111, 7'b1111111});
        check("rst_dp", dp, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("idle_hold", {gnt_a, gnt_b, frame_done, an, seg}, {2'b00, 1'b0, 4'b1111, 7'b1111111});
        end

        // B takes the idle display: P L - 1.
        data_b = {5'd16, 5'd17, 5'd18, 5'd1};
        mask_b = 4'b1111;
        req_b  = 1'b1;
        push_frame(data_b, mask_b);
        push_frame(data_b, mask_b);
        cyc();
        check("b_grant", {gnt_a, gnt_b}, 2'b01);
        check("b_grant_an", an, 4'b1111);
        for (int j = 1; j <= 32; j++) begin
            cyc();
            pop_check("b1_scan");
            if (j == 5)  req_b = 1'b0;
            if (j == 8)  req_b = 1'b1;
            if (j == 16) check("b_glitch_req", {gnt_a, gnt_b}, 2'b01);
            if (j == 20) begin
                req_b  = 1'b0;
                req_a  = 1'b1;
                data_a = {5'd9, 5'd5, 5'd2, 5'd3};
                mask_a = 4'b0011;
                push_frame({5'd9, 5'd5, 5'd2, 5'd3}, 4'b0011);
                push_frame({5'd9, 5'd5, 5'd2, 5'd7}, 4'b0011);
            end
            if (j == 31) check("b_before_bnd", {gnt_a, gnt_b}, 2'b01);
            if (j == 32) check("b_to_a", {gnt_a, gnt_b}, 2'b10);
        end

        // A owns with digits 2-3 masked; digit 0 changes mid-frame; B asks early.
        for (int j = 1; j <= 32; j++) begin
            cyc();
            pop_check("a_scan");
            if (j == 2) data_a[4:0] = 5'd7;
            if (j == 5) begin
                data_b = {5'd19, 5'd26, 5'd23, 5'd21};
                mask_b = 4'b1111;
                req_b  = 1'b1;
                push_frame({5'd19, 5'd26, 5'd23, 5'd21}, 4'b1111);
            end
            if (j == 16) check("a_hold", {gnt_a, gnt_b}, 2'b10);
            if (j == 31) check("a_hold2", {gnt_a, gnt_b}, 2'b10);
            if (j == 32) check("a_to_b", {gnt_a, gnt_b}, 2'b01);
        end

        // B shows H, blank, A, b; both requests drop and the display goes idle.
        for (int j = 1; j <= 16; j++) begin
            cyc();
            pop_check("b2_scan");
            if (j == 1) req_a = 1'b0;
            if (j == 6) begin
                req_b = 1'b0;
                push_idle(8);
            end
            if (j == 15) check("b2_hold", {gnt_a, gnt_b}, 2'b01);
            if (j == 16) check("b_to_idle", {gnt_a, gnt_b}, 2'b00);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            pop_check("idle_out");
        end

        // Reset in the middle of an A frame, with req_a still high.
        data_a = {5'd20, 5'd19, 5'd0, 5'd15};
        mask_a = 4'b1111;
        req_a  = 1'b1;
        cyc();
        check("a2_grant", {gnt_a, gnt_b}, 2'b10);
        push_frame(data_a, mask_a);
        for (int j = 1; j <= 6; j++) begin
            cyc();
            pop_check("a2_scan");
        end
        exp_q.delete();
        rst = 1'b1;
        cyc();
        check("rst_mid", {gnt_a, gnt_b, frame_done, an, seg}, {2'b00, 1'b0, 4'b1111, 7'b1111111});
        rst = 1'b0;
        cyc();
        check("rearb_a", {gnt_a, gnt_b}, 2'b10);
        check("rearb_an", an, 4'b1111);
        push_frame(data_a, mask_a);
        for (int j = 1; j <= 16; j++) begin
            cyc();
            pop_check("rearb_scan");
        end
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
